// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared constants and state encodings for the traffic controller
// Purpose: one-hot debounce state encodings, traffic FSM state constants and
//          the default debounce length shared by the traffic controller blocks.
// Ports:   none (package)
package traffic_pkg;

  // Default debounce length: 10 ms at 100 MHz.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

  // Debounce FSM states, one-hot.
  typedef enum logic [3:0] {
    STABLE_LO = 4'b0001,
    CHK_HI    = 4'b0010,
    STABLE_HI = 4'b0100,
    CHK_LO    = 4'b1000
  } db_state_t;

  // Traffic FSM state constants used by traffic_fsm.
  typedef enum logic [2:0] {
    TS_MAIN_GREEN  = 3'd0,
    TS_MAIN_YELLOW = 3'd1,
    TS_SIDE_GREEN  = 3'd2,
    TS_SIDE_YELLOW = 3'd3,
    TS_WALK        = 3'd4
  } traffic_state_t;

endpackage

// File: rtl/debounce.sv
// rtl/debounce.sv - two-flop synchronizer plus debounce FSM for one raw pin
// Purpose: synchronize an asynchronous, bouncy pin and only change the clean
//          level after DEBOUNCE_CYCLES consecutive stable synchronized cycles.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   raw    in  raw asynchronous pin
//   level  out debounced level
//   rise   out one-cycle pulse, high in the cycle level first reads 1
module debounce
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync_meta;
  logic             sync;
  db_state_t        state_q;
  db_state_t        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             rise_q;
  logic             rise_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync      <= sync_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  // The edge that leaves a STABLE state already counts as the first stable
  // cycle, so the counter starts at 1 and the level flips on the
  // DEBOUNCE_CYCLES-th consecutive sample. The counter tops out at CNT_LAST
  // and is cleared on every exit, so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    case (state_q)
      STABLE_LO: begin
        cnt_d = '0;
        if (sync) begin
          state_d = CHK_HI;
          cnt_d   = CNT_ONE;
        end
      end
      CHK_HI: begin
        if (!sync) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        cnt_d = '0;
        if (!sync) begin
          state_d = CHK_LO;
          cnt_d   = CNT_ONE;
        end
      end
      CHK_LO: begin
        if (sync) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  // Level is a pure function of the registered state: high while stable high
  // or while checking a possible release.
  assign level = (state_q == STABLE_HI) || (state_q == CHK_LO);
  assign rise  = rise_q;

endmodule

// File: rtl/traffic_input_cond.sv
// rtl/traffic_input_cond.sv - button/sensor conditioner and walk request latch
// Purpose: debounce the pedestrian button and side-street sensor and latch a
//          walk request that the traffic FSM acknowledges via ped_light.
// Ports:
//   clk             in  system clock
//   rst_n           in  asynchronous active-low reset
//   ped_btn_raw     in  raw pedestrian button pin
//   traf_sense_raw  in  raw side-street sensor pin
//   ped_light       in  walk light from the FSM, acts as request acknowledge
//   ped_btn         out latched walk request
//   traf_sense      out debounced sensor level
//   btn_level       out debounced button level
module traffic_input_cond
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ped_btn_raw,
  input  logic traf_sense_raw,
  input  logic ped_light,
  output logic ped_btn,
  output logic traf_sense,
  output logic btn_level
);

  logic btn_rise;
  logic sense_rise_unused;
  logic req_q;

  debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_btn_db (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (ped_btn_raw),
    .level(btn_level),
    .rise (btn_rise)
  );

  debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_sense_db (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (traf_sense_raw),
    .level(traf_sense),
    .rise (sense_rise_unused)
  );

  // ped_light is checked first so an acknowledge always beats a coincident
  // press, and presses during an active walk are dropped rather than queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= 1'b0;
    end else if (ped_light) begin
      req_q <= 1'b0;
    end else if (btn_rise) begin
      req_q <= 1'b1;
    end
  end

  assign ped_btn = req_q;

endmodule
